uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

UART receive front-end feeding the peripheral data register file. It samples the asynchronous `rx` line with 16x oversampling and assembles 8N1 frames. Each valid byte is written, zero-extended to 32 bits, into the register file's second write port through a self-incrementing address pointer. Framing errors are flagged, and the failed byte is never written.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9_600: line rate in baud; requires `CLK_FREQ/(BAUD*16) >= 2`, with integer truncation.
- `N`, 8: address width of the downstream register file.

- `clk`  in  1: single system clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx`  in  1: asynchronous serial input; idles high.
- `clr_ptr`  in  1: synchronous clear of the write pointer.
- `IN2`  out  32: write data, `{24'b0, byte}`.
- `WR2`  out  1: one-cycle write strobe.
- `addr2`  out  N: write address; equals the current pointer.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Reset values: `IN2`=0, `WR2`=0, `addr2`=0, `frame_err`=0, `busy`=0, pointer=0, FSM=IDLE, synchroniser flops=1.
- `rx` passes through a 2-flop synchroniser (`rx_s`); all decisions use `rx_s`.
- Baud tick: a divider `DIV = CLK_FREQ/(BAUD*16)` counts 0..DIV-1 and pulses `tick` at DIV-1. The divider restarts at 0 when leaving IDLE.
- A 4-bit sample counter counts ticks within a bit; a 3-bit bit index counts data bits.
- FSM:
  - IDLE: when `rx_s`=0, go to START and clear the counters.
  - START: on the 8th tick (mid-bit), if `rx_s`=0 go to DATA, otherwise return to IDLE (glitch reject).
  - DATA: every 16 ticks, shift `rx_s` in LSB-first. After bit 7, go to STOP.
  - STOP: at mid-stop (16 ticks after the last data sample):
    - if `rx_s`=1, go to WRITE;
    - otherwise pulse `frame_err` and go to WAIT_IDLE.
  - WRITE: a single clock with `WR2`=1, `IN2`={24'b0,byte}, `addr2`=pointer; then the pointer increments and the FSM returns to IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- Pointer wraps from 2**N-1 to 0.
- `clr_ptr` sets the pointer to 0 on the next edge in any state.
- `clr_ptr` coincident with WRITE: the write uses the old pointer, and the pointer becomes 0 (clear wins over increment).
- `rst` mid-frame aborts the frame: no write, no `frame_err`, all outputs return to reset values on the next edge.
- `IN2` and `addr2` hold their last written values between strobes.

## Timing
- `rx` edge to `rx_s`: 2 clocks.
- Start detection to the mid-start sample: 8 ticks. Each data bit: 16 ticks. Full frame to the stop sample: 9.5 bit times after the falling edge (+2 synchroniser clocks).
- `WR2` rises 1 clock after the stop-bit sample edge and lasts exactly 1 clock.
- `frame_err` rises on the same relative cycle and lasts exactly 1 clock.
- Back-to-back frames: a start bit arriving immediately after the stop sample is caught, because WRITE lasts 1 clock and the remaining half stop bit is spent in IDLE.
- Minimum spacing between `WR2` pulses: 1 frame time.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE, WAIT_IDLE} rx_state_t`;
  - `localparam OVERSAMPLE = 16`, `DATA_BITS = 8`.
- Sub-module `uart_baud_tick`, with ports `clk`, `rst`, `restart`, `tick` and parameter `DIV`. It is shared with the future transmitter.
- Top level holds the synchroniser, FSM, shift register, counters and pointer.

## Test plan
Bench parameters: `CLK_FREQ=1_600_000`, `BAUD=10_000` (DIV=10, 160 clocks/bit), `N=8`.
1. Send 0xA5 (8N1) after reset → one `WR2` pulse with `IN2`=0x000000A5 and `addr2`=0; the next byte 0x5A lands at `addr2`=1.
2. Drive `rx` low for 60 clocks, then high → FSM returns to IDLE, no `WR2`, `busy` drops, pointer unchanged.
3. Send 0x3C with stop bit 0, then hold `rx` low for 2 bit times → exactly one `frame_err` pulse, no `WR2`. The next valid 0x11 is written at the unchanged address.
4. Send 257 frames of incrementing data 0x00..0xFF,0x00 → last two writes at `addr2`=255 then 0.
5. Assert `clr_ptr` in the WRITE cycle of a frame at pointer 7 → write at `addr2`=7; the next frame writes at `addr2`=0.
6. Assert `rst` for 1 clock in the middle of bit 4 of a frame → no `WR2`/`frame_err`, all outputs 0. The next full frame 0xC3 is written at `addr2`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive front-end and the future transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WRITE,
    WAIT_IDLE
  } rx_state_t;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned SAMPLE_W    = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_IDX_W   = $clog2(DATA_BITS);
  localparam int unsigned MID_SAMPLE  = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST_SAMPLE = OVERSAMPLE - 1;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock tick every DIV clocks, restartable to phase 0.
module uart_baud_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver writing each good byte into the register file through an auto-incrementing pointer.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9_600,
  parameter int unsigned N        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              clr_ptr,
  output logic [WORD_W-1:0] IN2,
  output logic              WR2,
  output logic [N-1:0]      addr2,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

  rx_state_t              state, next_state;
  logic                   rx_m, rx_s;
  logic                   tick;
  logic                   restart_c, load_c, ferr_c, mid_c, last_c;
  logic [SAMPLE_W-1:0]    sample_cnt;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic [N-1:0]           ptr;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_c),
    .tick    (tick)
  );

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign mid_c  = tick && (sample_cnt == SAMPLE_W'(MID_SAMPLE));
  assign last_c = tick && (sample_cnt == SAMPLE_W'(LAST_SAMPLE));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    restart_c  = 1'b0;
    load_c     = 1'b0;
    ferr_c     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          next_state = START;
          restart_c  = 1'b1;
        end
      end
      START: begin
        if (mid_c) next_state = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (last_c && (bit_idx == BIT_IDX_W'(DATA_BITS - 1))) next_state = STOP;
      end
      STOP: begin
        if (last_c) begin
          if (rx_s) begin
            next_state = WRITE;
            load_c     = 1'b1;
          end else begin
            next_state = WAIT_IDLE;
            ferr_c     = 1'b1;
          end
        end
      end
      WRITE:     next_state = IDLE;
      WAIT_IDLE: if (rx_s) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Sample/bit counters and shift register; mid-start re-aligns sampling to bit centres.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
    end else if (restart_c) begin
      sample_cnt <= '0;
      bit_idx    <= '0;
    end else if (tick && (state == START || state == DATA || state == STOP)) begin
      if (state == START && mid_c) sample_cnt <= '0;
      else                         sample_cnt <= sample_cnt + SAMPLE_W'(1);
      if (state == DATA && last_c) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + BIT_IDX_W'(1);
      end
    end
  end

  // Registered outputs and write pointer; clear beats the post-write increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      IN2       <= '0;
      WR2       <= 1'b0;
      addr2     <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      ptr       <= '0;
    end else begin
      WR2       <= load_c;
      frame_err <= ferr_c;
      busy      <= (next_state != IDLE);
      if (load_c) begin
        IN2   <= WORD_W'(shreg);
        addr2 <= ptr;
      end
      if (clr_ptr)             ptr <= '0;
      else if (state == WRITE) ptr <= ptr + N'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: vector table of frames plus hand sequences, writes checked against a scoreboard.
module tb_uart_rx_ctrl;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int unsigned N        = 8;
  localparam int unsigned NW       = 4;
  localparam int          BIT      = 160;

  logic          clk = 1'b0;
  logic          rst, rx, clr_ptr, rx_w, clr_w;
  logic [31:0]   in2, in2_w;
  logic          wr2, wr2_w, frame_err, frame_err_w, busy, busy_w;
  logic [N-1:0]  addr2;
  logic [NW-1:0] addr2_w;

  uart_rx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .N(N)) dut (
    .clk(clk), .rst(rst), .rx(rx), .clr_ptr(clr_ptr),
    .IN2(in2), .WR2(wr2), .addr2(addr2), .frame_err(frame_err), .busy(busy)
  );

  // Narrow-pointer instance so wrap-around is reached in a short run.
  uart_rx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .N(NW)) dut_w (
    .clk(clk), .rst(rst), .rx(rx_w), .clr_ptr(clr_w),
    .IN2(in2_w), .WR2(wr2_w), .addr2(addr2_w), .frame_err(frame_err_w), .busy(busy_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  addr;
  } exp_t;

  typedef struct {
    int         kind;      // 0 = frame, 1 = start glitch
    logic [7:0] data;
    bit         stop_ok;
    bit         exp_wr;
    bit         exp_ferr;
    logic [7:0] exp_addr;
  } vec_t;

  exp_t q_a[$], q_w[$];
  exp_t ea, ew;
  int   checks = 0, errors = 0;
  int   wr_a = 0, ferr_a = 0, wr_w = 0, ferr_w = 0;
  bit   prev_wr_a = 0, prev_ferr_a = 0, prev_wr_w = 0;
  bit   seen;
  int   wa0, fa0;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr2) begin
      wr_a++;
      check("wr2_width", 32'(prev_wr_a), 32'd0);
      if (q_a.size() == 0) begin
        check("wr2_unexpected", 32'd1, 32'd0);
      end else begin
        ea = q_a.pop_front();
        check("in2", in2, ea.data);
        check("addr2", 32'(addr2), 32'(ea.addr));
      end
    end
    if (frame_err) begin
      ferr_a++;
      check("ferr_width", 32'(prev_ferr_a), 32'd0);
    end
    if (wr2_w) begin
      wr_w++;
      check("wrap_wr2_width", 32'(prev_wr_w), 32'd0);
      if (q_w.size() == 0) begin
        check("wrap_wr2_unexpected", 32'd1, 32'd0);
      end else begin
        ew = q_w.pop_front();
        check("wrap_in2", in2_w, ew.data);
        check("wrap_addr2", 32'(addr2_w), 32'(ew.addr));
      end
    end
    if (frame_err_w) ferr_w++;
    prev_wr_a   = wr2;
    prev_ferr_a = frame_err;
    prev_wr_w   = wr2_w;
  end

  task automatic tick_clks(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit w, input logic v);
    if (w) rx_w = v;
    else   rx   = v;
  endtask

  // One 8N1 frame; a bad stop bit is followed by two more bit times of break.
  task automatic send_frame(input bit w, input logic [7:0] d, input bit stop_ok, input int gap);
    drive(w, 1'b0);
    tick_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(w, d[i]);
      tick_clks(BIT);
    end
    if (stop_ok) begin
      drive(w, 1'b1);
      tick_clks(BIT);
    end else begin
      drive(w, 1'b0);
      tick_clks(3 * BIT);
      drive(w, 1'b1);
    end
    tick_clks(gap);
  endtask

  task automatic check_zero(input string name);
    check({name, "_in2"}, in2, 32'd0);
    check({name, "_wr2"}, 32'(wr2), 32'd0);
    check({name, "_addr2"}, 32'(addr2), 32'd0);
    check({name, "_ferr"}, 32'(frame_err), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{0, 8'h5A, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[2] = '{1, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[3] = '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[4] = '{0, 8'h11, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[5] = '{0, 8'h01, 1'b1, 1'b1, 1'b0, 8'd3};
    vecs[6] = '{0, 8'h02, 1'b1, 1'b1, 1'b0, 8'd4};
    vecs[7] = '{0, 8'h03, 1'b1, 1'b1, 1'b0, 8'd5};
    vecs[8] = '{0, 8'h04, 1'b1, 1'b1, 1'b0, 8'd6};

    rst = 1'b1; rx = 1'b1; rx_w = 1'b1; clr_ptr = 1'b0; clr_w = 1'b0;
    tick_clks(5);
    rst = 1'b0;
    tick_clks(3);
    check_zero("reset");

    // Good frames, start glitch, break; pointer ends at 7.
    foreach (vecs[i]) begin
      wa0 = wr_a;
      fa0 = ferr_a;
      if (vecs[i].kind == 0) begin
        if (vecs[i].exp_wr) q_a.push_back('{32'(vecs[i].data), vecs[i].exp_addr});
        send_frame(1'b0, vecs[i].data, vecs[i].stop_ok, BIT);
      end else begin
        drive(1'b0, 1'b0);
        tick_clks(30);
        check("glitch_busy_high", 32'(busy), 32'd1);
        tick_clks(30);
        drive(1'b0, 1'b1);
        tick_clks(2 * BIT);
      end
      check("vec_wr_count", 32'(wr_a - wa0), 32'(vecs[i].exp_wr));
      check("vec_ferr_count", 32'(ferr_a - fa0), 32'(vecs[i].exp_ferr));
      check("vec_busy_idle", 32'(busy), 32'd0);
    end

    // Clear pointer during the WRITE cycle of the write at address 7.
    q_a.push_back('{32'h77, 8'd7});
    seen = 1'b0;
    fork
      send_frame(1'b0, 8'h77, 1'b1, BIT);
      begin
        for (int k = 0; k < 2000 && !seen; k++) begin
          @(negedge clk);
          if (wr2) begin
            seen = 1'b1;
            clr_ptr = 1'b1;
            @(negedge clk);
            clr_ptr = 1'b0;
          end
        end
      end
    join
    check("clr_write_seen", 32'(seen), 32'd1);
    wa0 = wr_a;
    q_a.push_back('{32'h88, 8'd0});
    send_frame(1'b0, 8'h88, 1'b1, BIT);
    check("after_clr_wr_count", 32'(wr_a - wa0), 32'd1);

    // Reset in the middle of data bit 4 aborts the frame.
    wa0 = wr_a;
    fa0 = ferr_a;
    fork
      send_frame(1'b0, 8'hF0, 1'b1, BIT);
      begin
        tick_clks(5 * BIT + BIT / 2);
        rst = 1'b1;
        tick_clks(1);
        rst = 1'b0;
        @(negedge clk);
        check_zero("midframe_rst");
      end
    join
    check("rst_abort_wr", 32'(wr_a - wa0), 32'd0);
    check("rst_abort_ferr", 32'(ferr_a - fa0), 32'd0);
    q_a.push_back('{32'hC3, 8'd0});
    send_frame(1'b0, 8'hC3, 1'b1, BIT);
    check("after_rst_wr_count", 32'(wr_a - wa0), 32'd1);

    // Back-to-back frames through pointer wrap on the narrow instance.
    for (int i = 0; i <= (1 << NW); i++) begin
      q_w.push_back('{32'(i), 8'(i % (1 << NW))});
      send_frame(1'b1, 8'(i), 1'b1, 0);
    end
    tick_clks(BIT);
    check("wrap_wr_count", 32'(wr_w), 32'((1 << NW) + 1));
    check("wrap_ferr_count", 32'(ferr_w), 32'd0);
    check("wrap_busy_idle", 32'(busy_w), 32'd0);

    check("total_ferr", 32'(ferr_a), 32'd1);
    check("queue_a_empty", 32'(q_a.size()), 32'd0);
    check("queue_w_empty", 32'(q_w.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
